ram_rd_arbiter: RTL and testbench

- Front-end controller for the strobed, pipelined simple-dual-port UltraRAM wrapper.
- Shares the single RAM read port between two read requesters using round-robin arbitration. Passes one write stream through.
- Tracks in-flight reads through the RAM's fixed latency and steers each returned word to the requester that issued it.
- Stalls a read that targets the address being written in the same cycle, so reads never return pre-write data on that collision.

---
 rtl/ram_rd_arbiter.sv | 139 +++++++++++++
 tb/tb_ram_rd_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rd_arbiter.sv
// Front end for the strobed pipelined UltraRAM: one write stream passes through,
// two read requesters share the read port round-robin, responses are steered by tag.
module ram_rd_arbiter #(
    parameter  int ADDR_WIDTH  = 16,
    parameter  int DATA_WIDTH  = 128,
    parameter  int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter  int NPIPES      = 1,
    localparam int RAM_LATENCY = NPIPES + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_wr_addr,
    input  logic [DATA_WIDTH-1:0]   s_wr_data,
    input  logic [STRB_WIDTH-1:0]   s_wr_strb,
    input  logic                    s_wr_valid,
    output logic                    s_wr_ready,
    input  logic [2*ADDR_WIDTH-1:0] s_rd_addr,
    input  logic [1:0]              s_rd_valid,
    output logic [1:0]              s_rd_ready,
    output logic [DATA_WIDTH-1:0]   m_rd_data,
    output logic [1:0]              m_rd_valid,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   ram_waddr,
    output logic [ADDR_WIDTH-1:0]   ram_raddr,
    output logic [DATA_WIDTH-1:0]   ram_din,
    output logic [STRB_WIDTH-1:0]   ram_strb,
    output logic                    ram_ena,
    output logic                    ram_ren,
    output logic                    ram_wen,
    input  logic [DATA_WIDTH-1:0]   ram_dout
);

    logic                   wr_fire_s;
    logic [1:0]             cand_s;
    logic                   pick_valid_s;
    logic                   pick_id_s;
    logic [ADDR_WIDTH-1:0]  pick_addr_s;
    logic                   collide_s;
    logic                   grant_s;
    logic                   ptr_r;
    logic [RAM_LATENCY-1:0] tag_vld_r;
    logic [RAM_LATENCY-1:0] tag_id_r;

    assign wr_fire_s   = s_wr_valid & ~rst;
    assign cand_s      = s_rd_valid & {2{~rst}};
    assign pick_addr_s = pick_id_s ? s_rd_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                   : s_rd_addr[ADDR_WIDTH-1:0];

    // Round-robin selection among requesters presenting a read
    always_comb begin
        pick_valid_s = 1'b0;
        pick_id_s    = 1'b0;
        case (cand_s)
            2'b01: begin
                pick_valid_s = 1'b1;
                pick_id_s    = 1'b0;
            end
            2'b10: begin
                pick_valid_s = 1'b1;
                pick_id_s    = 1'b1;
            end
            2'b11: begin
                pick_valid_s = 1'b1;
                pick_id_s    = ptr_r;
            end
            default: begin
                pick_valid_s = 1'b0;
                pick_id_s    = 1'b0;
            end
        endcase
    end

    // A read to the address written this cycle waits so it never sees pre-write data
    assign collide_s = wr_fire_s & pick_valid_s & (pick_addr_s == s_wr_addr);
    assign grant_s   = pick_valid_s & ~collide_s;

    // Per-requester grant strobe
    always_comb begin
        s_rd_ready = 2'b00;
        if (grant_s) begin
            if (pick_id_s) begin
                s_rd_ready = 2'b10;
            end else begin
                s_rd_ready = 2'b01;
            end
        end else begin
            s_rd_ready = 2'b00;
        end
    end

    assign s_wr_ready = ~rst;
    assign ram_wen    = wr_fire_s;
    assign ram_waddr  = s_wr_addr;
    assign ram_din    = s_wr_data;
    assign ram_strb   = s_wr_strb;
    assign ram_ren    = grant_s;
    assign ram_raddr  = pick_addr_s;
    assign ram_ena    = grant_s | wr_fire_s;

    // Pointer favours the requester that lost the last grant
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 1'b0;
        end else if (grant_s) begin
            ptr_r <= ~pick_id_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Tag shift register mirrors the RAM read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_r <= {RAM_LATENCY{1'b0}};
            tag_id_r  <= {RAM_LATENCY{1'b0}};
        end else begin
            tag_vld_r <= {tag_vld_r[RAM_LATENCY-2:0], grant_s};
            tag_id_r  <= {tag_id_r[RAM_LATENCY-2:0], pick_id_s};
        end
    end

    // Steer the returning word to the requester that issued it
    always_comb begin
        m_rd_valid = 2'b00;
        if (tag_vld_r[RAM_LATENCY-1]) begin
            if (tag_id_r[RAM_LATENCY-1]) begin
                m_rd_valid = 2'b10;
            end else begin
                m_rd_valid = 2'b01;
            end
        end else begin
            m_rd_valid = 2'b00;
        end
    end

    assign m_rd_data = ram_dout;
    assign busy      = |tag_vld_r;

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// Bench for ram_rd_arbiter: two instances (NPIPES=1 and NPIPES=0) share one stimulus
// stream and are each checked against a queue-based reference model.
module tb_ram_rd_arbiter;
    localparam int AW = 16;
    localparam int DW = 128;
    localparam int SW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          ram_clr;
    logic [AW-1:0] s_wr_addr;
    logic [DW-1:0] s_wr_data;
    logic [SW-1:0] s_wr_strb;
    logic          s_wr_valid;
    logic [2*AW-1:0] s_rd_addr;
    logic [1:0]    s_rd_valid;

    logic          s_wr_ready_w [2];
    logic [1:0]    s_rd_ready_w [2];
    logic [DW-1:0] m_rd_data_w  [2];
    logic [1:0]    m_rd_valid_w [2];
    logic          busy_w       [2];
    logic [AW-1:0] ram_waddr_w  [2];
    logic [AW-1:0] ram_raddr_w  [2];
    logic [DW-1:0] ram_din_w    [2];
    logic [SW-1:0] ram_strb_w   [2];
    logic          ram_ena_w    [2];
    logic          ram_ren_w    [2];
    logic          ram_wen_w    [2];
    logic [DW-1:0] ram_dout_w   [2];

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int NP  = (g == 0) ? 1 : 0;
        localparam int LAT = NP + 2;
        logic [DW-1:0] mem  [256];
        logic [DW-1:0] pipe [LAT];

        ram_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .NPIPES(NP)) dut (
            .clk(clk), .rst(rst),
            .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data), .s_wr_strb(s_wr_strb),
            .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready_w[g]),
            .s_rd_addr(s_rd_addr), .s_rd_valid(s_rd_valid), .s_rd_ready(s_rd_ready_w[g]),
            .m_rd_data(m_rd_data_w[g]), .m_rd_valid(m_rd_valid_w[g]), .busy(busy_w[g]),
            .ram_waddr(ram_waddr_w[g]), .ram_raddr(ram_raddr_w[g]), .ram_din(ram_din_w[g]),
            .ram_strb(ram_strb_w[g]), .ram_ena(ram_ena_w[g]), .ram_ren(ram_ren_w[g]),
            .ram_wen(ram_wen_w[g]), .ram_dout(ram_dout_w[g])
        );

        // Behavioural RAM: read issued at an edge appears LAT cycles later
        always @(posedge clk) begin
            if (ram_clr) begin
                for (int i = 0; i < 256; i++) mem[i] <= '0;
            end else if (ram_ena_w[g] && ram_wen_w[g]) begin
                for (int b = 0; b < SW; b++)
                    if (ram_strb_w[g][b]) mem[ram_waddr_w[g][7:0]][b*8 +: 8] <= ram_din_w[g][b*8 +: 8];
            end
            if (ram_ena_w[g] && ram_ren_w[g]) pipe[0] <= mem[ram_raddr_w[g][7:0]];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign ram_dout_w[g] = pipe[LAT-1];
    end

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          rq [2][$];
    logic [DW-1:0] shadow [256];
    int            cyc;
    int            ptr;
    int            errors;
    int            checks;

    function automatic int lat(input int k);
        return (k == 0) ? 3 : 2;
    endfunction

    task automatic chk(input string tag, input int k, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cfg%0d cyc%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [SW-1:0] ws, input logic [1:0] rv,
                        input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        logic [1:0]    cand;
        logic [1:0]    exp_rdy;
        logic [1:0]    exp_v;
        logic [DW-1:0] exp_d;
        logic [AW-1:0] paddr;
        logic          wfire;
        logic          coll;
        logic          gnt;
        logic          exp_busy;
        int            pick;
        rsp_t          e;
        @(negedge clk);
        rst = r; s_wr_valid = wv; s_wr_addr = wa; s_wr_data = wd; s_wr_strb = ws;
        s_rd_valid = rv; s_rd_addr = {ra1, ra0};
        #1;
        wfire   = wv && !r;
        cand    = r ? 2'b00 : rv;
        pick    = (cand == 2'b11) ? ptr : (cand[1] ? 1 : 0);
        paddr   = (pick == 1) ? ra1 : ra0;
        coll    = wfire && (cand != 2'b00) && (paddr == wa);
        gnt     = (cand != 2'b00) && !coll;
        exp_rdy = gnt ? ((pick == 1) ? 2'b10 : 2'b01) : 2'b00;
        for (int k = 0; k < 2; k++) begin
            chk("s_wr_ready", k, DW'(s_wr_ready_w[k]), DW'(!r));
            chk("s_rd_ready", k, DW'(s_rd_ready_w[k]), DW'(exp_rdy));
            chk("ram_wen", k, DW'(ram_wen_w[k]), DW'(wfire));
            chk("ram_ren", k, DW'(ram_ren_w[k]), DW'(gnt));
            chk("ram_ena", k, DW'(ram_ena_w[k]), DW'(gnt || wfire));
            if (gnt) chk("ram_raddr", k, DW'(ram_raddr_w[k]), DW'(paddr));
            if (wfire) chk("ram_waddr", k, DW'(ram_waddr_w[k]), DW'(wa));
            exp_busy = (rq[k].size() != 0);
            exp_v = 2'b00;
            exp_d = '0;
            if (rq[k].size() != 0 && rq[k][0].due == cyc) begin
                e = rq[k].pop_front();
                exp_v = (e.id == 1) ? 2'b10 : 2'b01;
                exp_d = e.data;
            end
            chk("m_rd_valid", k, DW'(m_rd_valid_w[k]), DW'(exp_v));
            if (exp_v != 2'b00) chk("m_rd_data", k, m_rd_data_w[k], exp_d);
            chk("busy", k, DW'(busy_w[k]), DW'(exp_busy));
        end
        if (r) begin
            rq[0].delete();
            rq[1].delete();
            ptr = 0;
        end else begin
            if (gnt) begin
                for (int k = 0; k < 2; k++) begin
                    e.due  = cyc + lat(k);
                    e.id   = pick;
                    e.data = shadow[paddr[7:0]];
                    rq[k].push_back(e);
                end
                ptr = 1 - pick;
            end
            if (wfire)
                for (int b = 0; b < SW; b++)
                    if (ws[b]) shadow[wa[7:0]][b*8 +: 8] = wd[b*8 +: 8];
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 2'b00, '0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        step(1'b0, 1'b1, a, d, s, 2'b00, '0, '0);
    endtask

    logic [DW-1:0] rnd_d;

    initial begin
        errors = 0; checks = 0; cyc = 0; ptr = 0;
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        rst = 1'b1; ram_clr = 1'b1; s_wr_valid = 1'b0; s_wr_addr = '0; s_wr_data = '0;
        s_wr_strb = '0; s_rd_valid = 2'b00; s_rd_addr = '0;
        step(1'b1, 1'b0, '0, '0, '0, 2'b00, '0, '0);
        step(1'b1, 1'b0, '0, '0, '0, 2'b00, '0, '0);
        ram_clr = 1'b0;
        idle(1);

        // write then read back through requester 0
        wr(16'h0010, {16{8'hA5}}, 16'hFFFF);
        step(1'b0, 1'b0, '0, '0, '0, 2'b01, 16'h0010, '0);
        idle(4);

        // continuous contention from a fresh pointer
        wr(16'h0001, {16{8'h11}}, 16'hFFFF);
        wr(16'h0002, {16{8'h22}}, 16'hFFFF);
        step(1'b1, 1'b0, '0, '0, '0, 2'b00, '0, '0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, '0, '0, 2'b11, 16'h0001, 16'h0002);
        idle(4);

        // same-cycle write/read collision, then retry
        step(1'b0, 1'b1, 16'h0020, DW'(32'h1234), 16'hFFFF, 2'b01, 16'h0020, '0);
        step(1'b0, 1'b0, '0, '0, '0, 2'b01, 16'h0020, '0);
        idle(4);

        // partial strobe write and an all-zero strobe write
        wr(16'h0030, {16{8'hFF}}, 16'hFFFF);
        wr(16'h0030, '0, 16'h00FF);
        wr(16'h0030, '0, 16'h0000);
        step(1'b0, 1'b0, '0, '0, '0, 2'b01, 16'h0030, '0);
        idle(4);

        // write and read to different addresses in the same cycle
        step(1'b0, 1'b1, 16'h0040, {4{32'hCAFE_F00D}}, 16'hFFFF, 2'b10, '0, 16'h0010);
        // requester 1 alone
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, '0, 2'b10, '0, 16'h0040);
        idle(4);

        // reset while reads are in flight
        step(1'b0, 1'b0, '0, '0, '0, 2'b01, 16'h0010, '0);
        step(1'b0, 1'b0, '0, '0, '0, 2'b01, 16'h0020, '0);
        step(1'b0, 1'b0, '0, '0, '0, 2'b01, 16'h0030, '0);
        step(1'b1, 1'b0, '0, '0, '0, 2'b00, '0, '0);
        idle(5);

        // randomized traffic over a small address window to force collisions
        for (int i = 0; i < 400; i++) begin
            rnd_d = {$urandom, $urandom, $urandom, $urandom};
            step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                 rnd_d, SW'($urandom), 2'($urandom_range(0, 3)),
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
